// File: rtl/strait_test_sequencer.sv
// Walks the masked STRAIT arrays lowest-first through MBIST, LBIST and BISR recovery, with a watchdog on every wait.
// Optional feature macro STRAIT_RETEST_EN: a successful recovery re-runs LBIST once before the array is released.
module strait_test_sequencer #(
  parameter int unsigned NUM_ARRAYS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned IDX_WIDTH      = $clog2(NUM_ARRAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_ARRAYS-1:0] array_mask,
  output logic [NUM_ARRAYS-1:0] array_start,
  output logic                  bist_mode,
  output logic [NUM_ARRAYS-1:0] array_test_mode,
  input  logic [NUM_ARRAYS-1:0] array_test_done,
  input  logic [NUM_ARRAYS-1:0] array_mbist_result,
  input  logic [NUM_ARRAYS-1:0] array_lbist_result,
  input  logic [NUM_ARRAYS-1:0] array_recovery_done,
  input  logic [NUM_ARRAYS-1:0] array_recovery_success,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_WIDTH-1:0]  cur_array,
  output logic [NUM_ARRAYS-1:0] fail_map,
  output logic [NUM_ARRAYS-1:0] timeout_map
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SELECT     = 4'd1,
    MB_START   = 4'd2,
    MB_WAIT    = 4'd3,
    LB_START   = 4'd4,
    LB_WAIT_SA = 4'd5,
    LB_WAIT_TD = 4'd6,
    REC_WAIT   = 4'd7,
    NEXT       = 4'd8,
    FINISH     = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_ARRAYS-1:0] pending_q, pending_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [IDX_WIDTH-1:0]  cur_d;
  logic [NUM_ARRAYS-1:0] fail_d, tmo_d;
  logic [NUM_ARRAYS-1:0] start_d, tmode_d, sel_onehot;
  logic                  mode_d, busy_d, done_d;
  logic                  is_wait, evt;
`ifdef STRAIT_RETEST_EN
  logic                  retest_q, retest_d;
`endif

  // Only the selected array's handshakes are visible to the FSM.
  logic sel_done, sel_mb_pass, sel_lb_pass, sel_rec_done, sel_rec_ok;
  assign sel_done     = array_test_done[cur_array];
  assign sel_mb_pass  = array_mbist_result[cur_array];
  assign sel_lb_pass  = array_lbist_result[cur_array];
  assign sel_rec_done = array_recovery_done[cur_array];
  assign sel_rec_ok   = array_recovery_success[cur_array];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      wdog_q          <= '0;
      cur_array       <= '0;
      fail_map        <= '0;
      timeout_map     <= '0;
      array_start     <= '0;
      bist_mode       <= 1'b0;
      array_test_mode <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef STRAIT_RETEST_EN
      retest_q        <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      wdog_q          <= wdog_d;
      cur_array       <= cur_d;
      fail_map        <= fail_d;
      timeout_map     <= tmo_d;
      array_start     <= start_d;
      bist_mode       <= mode_d;
      array_test_mode <= tmode_d;
      busy            <= busy_d;
      done            <= done_d;
`ifdef STRAIT_RETEST_EN
      retest_q        <= retest_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    wdog_d    = wdog_q;
    cur_d     = cur_array;
    fail_d    = fail_map;
    tmo_d     = timeout_map;
    is_wait   = 1'b0;
    evt       = 1'b0;
`ifdef STRAIT_RETEST_EN
    retest_d  = retest_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          pending_d = array_mask;
          fail_d    = '0;
          tmo_d     = '0;
          state_d   = SELECT;
        end
      end
      SELECT: begin
        state_d = FINISH;
`ifdef STRAIT_RETEST_EN
        retest_d = 1'b0;
`endif
        // Descending scan so the lowest pending index is the last to win.
        for (int i = int'(NUM_ARRAYS) - 1; i >= 0; i--) begin
          if (pending_q[i]) begin
            cur_d   = IDX_WIDTH'(i);
            state_d = MB_START;
          end
        end
      end
      MB_START: begin
        wdog_d  = '0;
        state_d = MB_WAIT;
      end
      MB_WAIT: begin
        is_wait = 1'b1;
        evt     = sel_done;
        if (sel_done) begin
          if (sel_mb_pass) begin
            state_d = LB_START;
          end else begin
            fail_d[cur_array] = 1'b1;
            state_d           = NEXT;
          end
        end
      end
      LB_START: begin
        wdog_d  = '0;
        state_d = LB_WAIT_SA;
      end
      LB_WAIT_SA: begin
        is_wait = 1'b1;
        evt     = sel_done;
        if (sel_done) begin
          wdog_d  = '0;
          state_d = LB_WAIT_TD;
        end
      end
      LB_WAIT_TD: begin
        is_wait = 1'b1;
        evt     = sel_done;
        if (sel_done) begin
          if (sel_lb_pass) begin
            state_d = NEXT;
`ifdef STRAIT_RETEST_EN
          end else if (retest_q) begin
            fail_d[cur_array] = 1'b1;
            state_d           = NEXT;
`endif
          end else begin
            wdog_d  = '0;
            state_d = REC_WAIT;
          end
        end
      end
      REC_WAIT: begin
        is_wait = 1'b1;
        evt     = sel_rec_done;
        if (sel_rec_done) begin
          if (sel_rec_ok) begin
`ifdef STRAIT_RETEST_EN
            retest_d = 1'b1;
            state_d  = LB_START;
`else
            state_d  = NEXT;
`endif
          end else begin
            fail_d[cur_array] = 1'b1;
            state_d           = NEXT;
          end
        end
      end
      NEXT: begin
        pending_d[cur_array] = 1'b0;
        state_d              = SELECT;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Watchdog shared by all wait states; a same-cycle event takes priority.
    if (is_wait && !evt) begin
      if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
        fail_d[cur_array] = 1'b1;
        tmo_d[cur_array]  = 1'b1;
        state_d           = NEXT;
      end else begin
        wdog_d = WDOG_W'(wdog_q + 1'b1);
      end
    end

    sel_onehot = NUM_ARRAYS'(1) << cur_d;
    start_d    = (state_d == MB_START || state_d == LB_START) ? sel_onehot : '0;
    mode_d     = (state_d == LB_START || state_d == LB_WAIT_SA || state_d == LB_WAIT_TD);
    tmode_d    = (state_d == MB_START || state_d == MB_WAIT || state_d == LB_START ||
                  state_d == LB_WAIT_SA || state_d == LB_WAIT_TD || state_d == REC_WAIT)
                 ? sel_onehot : '0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
  end

endmodule

// File: tb/tb_strait_test_sequencer.sv
// Scoreboard bench for strait_test_sequencer: a behavioural array responder plus expected start/done queues.
module tb_strait_test_sequencer;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;

  typedef struct packed { logic [1:0] idx; logic mode; } start_exp_t;
  typedef struct packed { logic [3:0] fail; logic [3:0] tmo; } done_exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] array_mask;
  logic [N-1:0] array_start;
  logic         bist_mode;
  logic [N-1:0] array_test_mode;
  logic [N-1:0] array_test_done, array_mbist_result, array_lbist_result;
  logic [N-1:0] array_recovery_done, array_recovery_success;
  logic         busy, done;
  logic [1:0]   cur_array;
  logic [N-1:0] fail_map, timeout_map;

  // Per-array behaviour of the modelled arrays.
  logic [N-1:0] cfg_mb, cfg_lb1, cfg_lb2, cfg_rec, cfg_silent, cfg_hang;
  logic [N-1:0] resp_td, resp_rd, resp_lb, stray_td, stray_rd;

  start_exp_t exp_starts[$];
  done_exp_t  exp_done[$];
  int vectors = 0;
  int miscompares = 0;

  assign array_test_done        = resp_td | stray_td;
  assign array_recovery_done    = resp_rd | stray_rd;
  assign array_mbist_result     = cfg_mb;
  assign array_lbist_result     = resp_lb;
  assign array_recovery_success = cfg_rec;

  strait_test_sequencer #(.NUM_ARRAYS(N), .TIMEOUT_CYCLES(TMO), .IDX_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .array_mask(array_mask),
    .array_start(array_start), .bist_mode(bist_mode), .array_test_mode(array_test_mode),
    .array_test_done(array_test_done), .array_mbist_result(array_mbist_result),
    .array_lbist_result(array_lbist_result), .array_recovery_done(array_recovery_done),
    .array_recovery_success(array_recovery_success), .busy(busy), .done(done),
    .cur_array(cur_array), .fail_map(fail_map), .timeout_map(timeout_map)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] one = 4'b0001;
    return one << i;
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

  task automatic cfg_all_pass();
    cfg_mb = '1; cfg_lb1 = '1; cfg_lb2 = '1; cfg_rec = '1; cfg_silent = '0; cfg_hang = '0;
  endtask

  // Reference model: expected start pulses and final maps for a mask under the current behaviour.
  task automatic build_expect(input logic [3:0] mask);
    done_exp_t d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        exp_starts.push_back({2'(i), 1'b0});
        if (cfg_silent[i]) begin
          d.fail[i] = 1'b1;
          d.tmo[i]  = 1'b1;
        end else if (!cfg_mb[i]) begin
          d.fail[i] = 1'b1;
        end else begin
          exp_starts.push_back({2'(i), 1'b1});
          if (!cfg_lb1[i]) begin
            if (!cfg_rec[i]) begin
              d.fail[i] = 1'b1;
            end else begin
`ifdef STRAIT_RETEST_EN
              exp_starts.push_back({2'(i), 1'b1});
              if (!cfg_lb2[i]) d.fail[i] = 1'b1;
`endif
            end
          end
        end
      end
    end
    exp_done.push_back(d);
  endtask

  task automatic pulse_td(input int idx);
    resp_td[idx] = 1'b1;
    @(negedge clk);
    resp_td[idx] = 1'b0;
  endtask

  task automatic pulse_rd(input int idx);
    resp_rd[idx] = 1'b1;
    @(negedge clk);
    resp_rd[idx] = 1'b0;
  endtask

  // Array responder: answers each START pulse after a few cycles.
  initial begin : responder
    int idx;
    int lb_try;
    logic mode;
    resp_td = '0; resp_rd = '0; resp_lb = '0; lb_try = 0;
    forever begin
      if (rst_n === 1'b1 && array_start != '0) begin
        idx  = int'(lowest(array_start));
        mode = bist_mode;
        if (!mode) lb_try = 0;
        repeat (3) @(negedge clk);
        if (!cfg_silent[idx]) begin
          if (!mode) begin
            pulse_td(idx);
          end else begin
            pulse_td(idx);
            if (!cfg_hang[idx]) begin
              repeat (2) @(negedge clk);
              resp_lb[idx] = (lb_try == 0) ? cfg_lb1[idx] : cfg_lb2[idx];
              pulse_td(idx);
              if (!resp_lb[idx] && lb_try == 0) begin
                repeat (2) @(negedge clk);
                pulse_rd(idx);
              end
              lb_try++;
            end
          end
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Scoreboard: pops an expectation on every START pulse and every done pulse.
  initial begin : monitor
    start_exp_t e;
    done_exp_t  d;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (array_start != '0) begin
          if (exp_starts.size() == 0) begin
            check("unexpected_start", 32'(array_start), 32'd0);
          end else begin
            e = exp_starts.pop_front();
            check("start_sel", 32'(array_start), 32'(onehot(e.idx)));
            check("start_mode", 32'(bist_mode), 32'(e.mode));
            check("start_cur_array", 32'(cur_array), 32'(e.idx));
            check("start_test_mode", 32'(array_test_mode), 32'(onehot(e.idx)));
          end
        end
        if (done) begin
          if (exp_done.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            d = exp_done.pop_front();
            check("done_fail_map", 32'(fail_map), 32'(d.fail));
            check("done_timeout_map", 32'(timeout_map), 32'(d.tmo));
          end
        end
      end
    end
  end

  task automatic launch(input logic [3:0] mask);
    @(negedge clk);
    start = 1'b1;
    array_mask = mask;
    @(negedge clk);
    start = 1'b0;
    array_mask = ~mask;
    check("busy_on_accept", 32'(busy), 32'd1);
    check("fail_map_cleared", 32'(fail_map), 32'd0);
    check("timeout_map_cleared", 32'(timeout_map), 32'd0);
    @(negedge clk);
    if (mask != 4'd0) check("start_latency", 32'(array_start), 32'(onehot(lowest(mask))));
    else              check("empty_done_latency", 32'(done), 32'd1);
  endtask

  task automatic finish_campaign();
    done_exp_t d;
    bit seen;
    d = (exp_done.size() > 0) ? exp_done[0] : '0;
    seen = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("busy_off", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("fail_map_hold", 32'(fail_map), 32'(d.fail));
    check("timeout_map_hold", 32'(timeout_map), 32'(d.tmo));
    check("starts_outstanding", 32'(exp_starts.size()), 32'd0);
    check("dones_outstanding", 32'(exp_done.size()), 32'd0);
  endtask

  task automatic run(input logic [3:0] mask);
    build_expect(mask);
    launch(mask);
    finish_campaign();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_array_start"}, 32'(array_start), 32'd0);
    check({tag, "_bist_mode"}, 32'(bist_mode), 32'd0);
    check({tag, "_test_mode"}, 32'(array_test_mode), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cur_array"}, 32'(cur_array), 32'd0);
    check({tag, "_fail_map"}, 32'(fail_map), 32'd0);
    check({tag, "_timeout_map"}, 32'(timeout_map), 32'd0);
  endtask

  initial begin : main
    int n;
    bit seen;
    rst_n = 1'b1; start = 1'b0; array_mask = '0; stray_td = '0; stray_rd = '0;
    cfg_all_pass();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run(4'b0101);

    cfg_mb[1] = 1'b0;
    run(4'b0010);
    cfg_all_pass();

    cfg_lb1[0] = 1'b0;
    run(4'b0001);
    cfg_all_pass();

    cfg_mb[1] = 1'b0; cfg_lb1[2] = 1'b0; cfg_rec[2] = 1'b0; cfg_lb1[3] = 1'b0; cfg_lb2[3] = 1'b0;
    run(4'b1111);
    cfg_all_pass();

    // Silent array: MBIST wait expires after TMO cycles, map visible the cycle after.
    cfg_silent[3] = 1'b1;
    build_expect(4'b1000);
    launch(4'b1000);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n++;
      if (timeout_map[3]) break;
    end
    check("timeout_latency", 32'(n), 32'(TMO + 1));
    finish_campaign();
    cfg_all_pass();

    run(4'b0000);

    // Restart attempt and stray handshakes from unselected arrays during MB_WAIT.
    cfg_mb[2] = 1'b0; cfg_rec[2] = 1'b0; cfg_rec[1] = 1'b0;
    build_expect(4'b0001);
    launch(4'b0001);
    @(negedge clk);
    start = 1'b1; array_mask = 4'b1111; stray_td = 4'b0100; stray_rd = 4'b0110;
    @(negedge clk);
    start = 1'b0; stray_td = '0; stray_rd = '0;
    check("stray_busy", 32'(busy), 32'd1);
    check("stray_fail_map", 32'(fail_map), 32'd0);
    check("stray_timeout_map", 32'(timeout_map), 32'd0);
    check("stray_cur_array", 32'(cur_array), 32'd0);
    check("stray_test_mode", 32'(array_test_mode), 32'b0001);
    check("stray_bist_mode", 32'(bist_mode), 32'd0);
    finish_campaign();
    cfg_all_pass();

    // Reset while array 1 sits in LB_WAIT_TD with array 0 already failed.
    cfg_mb[0] = 1'b0; cfg_hang[1] = 1'b1;
    exp_starts.push_back({2'd0, 1'b0});
    exp_starts.push_back({2'd1, 1'b0});
    exp_starts.push_back({2'd1, 1'b1});
    launch(4'b0011);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (array_start == 4'b0010 && bist_mode) begin
        seen = 1'b1;
        break;
      end
    end
    check("lbist_start_seen", 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    check("pre_reset_bist_mode", 32'(bist_mode), 32'd1);
    check("pre_reset_test_mode", 32'(array_test_mode), 32'b0010);
    check("pre_reset_fail_map", 32'(fail_map), 32'b0001);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    exp_starts.delete();
    exp_done.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cfg_all_pass();
    run(4'b0101);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not complete by %0t", $time);
    $fatal(1, "bench stuck");
  end

endmodule
